// File: rtl/gpio_ctrl.sv
// GPIO output bank controller: memory-mapped OUT register with set/clear/toggle aliases,
// a per-bit hardware blink sequencer and synchronized input readback.
module gpio_ctrl #(
    parameter int unsigned NR_GPIOS = 8,
    parameter int unsigned DIV_BITS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_req_valid,
    output logic                bus_req_ready,
    input  logic                bus_req_wr,
    input  logic [4:0]          bus_req_addr,
    input  logic [31:0]         bus_req_wdata,
    output logic                bus_rsp_valid,
    output logic [31:0]         bus_rsp_rdata,
    output logic [NR_GPIOS-1:0] gpio_out,
    input  logic [NR_GPIOS-1:0] gpio_in
);

    localparam logic [2:0] AddrOut      = 3'd0;
    localparam logic [2:0] AddrSet      = 3'd1;
    localparam logic [2:0] AddrClr      = 3'd2;
    localparam logic [2:0] AddrTgl      = 3'd3;
    localparam logic [2:0] AddrBlinkEn  = 3'd4;
    localparam logic [2:0] AddrBlinkDiv = 3'd5;
    localparam logic [2:0] AddrIn       = 3'd6;

    logic [NR_GPIOS-1:0] out_q, out_d;
    logic [NR_GPIOS-1:0] blink_en_q, blink_en_d;
    logic [DIV_BITS-1:0] blink_div_q, blink_div_d;
    logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic                phase_q, phase_d;
    logic [NR_GPIOS-1:0] gpio_out_q, gpio_out_d;
    logic [NR_GPIOS-1:0] sync1_q, sync2_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

    logic                wr_fire, rd_fire, div_write;
    logic [2:0]          word_addr;
    logic [NR_GPIOS-1:0] wdata_gpio;
    logic [DIV_BITS-1:0] wdata_div;
    logic                unused_bits;

    assign bus_req_ready = 1'b1;
    assign wr_fire       = bus_req_valid && bus_req_wr;
    assign rd_fire       = bus_req_valid && !bus_req_wr;
    assign word_addr     = bus_req_addr[4:2];
    assign wdata_gpio    = bus_req_wdata[NR_GPIOS-1:0];
    assign wdata_div     = bus_req_wdata[DIV_BITS-1:0];
    assign unused_bits   = ^{bus_req_addr[1:0], bus_req_wdata};

    always_comb begin
        out_d       = out_q;
        blink_en_d  = blink_en_q;
        blink_div_d = blink_div_q;
        div_write   = 1'b0;
        if (wr_fire) begin
            case (word_addr)
                AddrOut:      out_d = wdata_gpio;
                AddrSet:      out_d = out_q | wdata_gpio;
                AddrClr:      out_d = out_q & ~wdata_gpio;
                AddrTgl:      out_d = out_q ^ wdata_gpio;
                AddrBlinkEn:  blink_en_d = wdata_gpio;
                AddrBlinkDiv: begin
                    blink_div_d = wdata_div;
                    div_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A divisor write restarts the half-period from zero with phase low.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_BITS'(1);
        phase_d   = phase_q;
        if (div_write) begin
            div_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (div_cnt_q == blink_div_q) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_comb begin
        rsp_rdata_d = '0;
        if (rd_fire) begin
            case (word_addr)
                AddrOut:      rsp_rdata_d = 32'(out_q);
                AddrBlinkEn:  rsp_rdata_d = 32'(blink_en_q);
                AddrBlinkDiv: rsp_rdata_d = 32'(blink_div_q);
                AddrIn:       rsp_rdata_d = 32'(sync2_q);
                default:      rsp_rdata_d = '0;
            endcase
        end
    end

    assign gpio_out_d = out_q ^ (blink_en_q & {NR_GPIOS{phase_q}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            blink_en_q  <= '0;
            blink_div_q <= '0;
            div_cnt_q   <= '0;
            phase_q     <= 1'b0;
            gpio_out_q  <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            out_q       <= out_d;
            blink_en_q  <= blink_en_d;
            blink_div_q <= blink_div_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            gpio_out_q  <= gpio_out_d;
            sync1_q     <= gpio_in;
            sync2_q     <= sync1_q;
            rsp_valid_q <= bus_req_valid;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign gpio_out      = gpio_out_q;
    assign bus_rsp_valid = rsp_valid_q;
    assign bus_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed vector table, hand-written blink/sync/reset
// sequences and randomized traffic against a behavioural model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req_valid, bus_req_ready, bus_req_wr;
    logic [4:0]  bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic [7:0]  gpio_out, gpio_in;

    gpio_ctrl #(.NR_GPIOS(8), .DIV_BITS(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_wr   (bus_req_wr),
        .bus_req_addr (bus_req_addr),
        .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: register contents plus the number of edges since the divisor was last written;
    // the blink phase is derived arithmetically from that count.
    logic [31:0]     m_out, m_en, m_div, m_s1, m_s2;
    longint unsigned m_since;
    logic            e_rsp;
    logic [31:0]     e_rdata;
    logic [7:0]      e_gpio;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_gpio;
    } vec_t;
    vec_t vecs[16];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_phase();
        return ((m_since / (64'(m_div) + 64'd1)) % 64'd2) == 64'd1;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return m_out;
            3'd4:    return m_en;
            3'd5:    return m_div;
            3'd6:    return m_s2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_en = 0; m_div = 0; m_s1 = 0; m_s2 = 0; m_since = 0;
        e_rsp = 0; e_rdata = 0; e_gpio = 0;
    endtask

    task automatic model_edge(input logic v, input logic w, input logic [4:0] a,
                              input logic [31:0] d);
        e_gpio  = m_out[7:0] ^ (m_en[7:0] & {8{model_phase()}});
        e_rsp   = v;
        e_rdata = (v && !w) ? model_read(a) : 32'h0;
        m_s2    = m_s1;
        m_s1    = {24'h0, gpio_in};
        m_since = m_since + 1;
        if (v && w) begin
            case (a[4:2])
                3'd0: m_out = d & 32'hFF;
                3'd1: m_out = (m_out | d) & 32'hFF;
                3'd2: m_out = m_out & ~d & 32'hFF;
                3'd3: m_out = (m_out ^ d) & 32'hFF;
                3'd4: m_en  = d & 32'hFF;
                3'd5: begin m_div = d & 32'hFF_FFFF; m_since = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check32({tag, " rsp_valid"}, {31'h0, bus_rsp_valid}, {31'h0, e_rsp});
        check32({tag, " rdata"}, bus_rsp_rdata, e_rdata);
        check32({tag, " gpio_out"}, {24'h0, gpio_out}, {24'h0, e_gpio});
    endtask

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic step(input logic v, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input string tag);
        bus_req_valid = v; bus_req_wr = w; bus_req_addr = a; bus_req_wdata = d;
        @(posedge clk);
        model_edge(v, w, a, d);
        #1;
        check_outputs(tag);
        @(negedge clk);
        bus_req_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 5'h0, 32'h0, tag);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 32'h0000_00A5, 32'h0, 8'h00};
        vecs[1]  = '{1'b0, 5'h00, 32'h0,         32'hA5, 8'hA5};
        vecs[2]  = '{1'b1, 5'h04, 32'h0000_000F, 32'h0, 8'hA5};
        vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'hAF, 8'hAF};
        vecs[4]  = '{1'b1, 5'h08, 32'h0000_0081, 32'h0, 8'hAF};
        vecs[5]  = '{1'b0, 5'h00, 32'h0,         32'h2E, 8'h2E};
        vecs[6]  = '{1'b1, 5'h0C, 32'h0000_00FF, 32'h0, 8'h2E};
        vecs[7]  = '{1'b0, 5'h00, 32'h0,         32'hD1, 8'hD1};
        vecs[8]  = '{1'b0, 5'h04, 32'h0,         32'h0, 8'hD1};
        vecs[9]  = '{1'b0, 5'h08, 32'h0,         32'h0, 8'hD1};
        vecs[10] = '{1'b0, 5'h0C, 32'h0,         32'h0, 8'hD1};
        vecs[11] = '{1'b0, 5'h1C, 32'h0,         32'h0, 8'hD1};
        vecs[12] = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 32'h0, 8'hD1};
        vecs[13] = '{1'b0, 5'h00, 32'h0,         32'hD1, 8'hD1};
        vecs[14] = '{1'b1, 5'h01, 32'hFFFF_FF3C, 32'h0, 8'hD1};
        vecs[15] = '{1'b0, 5'h02, 32'h0,         32'h3C, 8'h3C};

        reset = 1'b1; bus_req_valid = 0; bus_req_wr = 0; bus_req_addr = 0; bus_req_wdata = 0;
        gpio_in = 8'h00;
        model_reset();
        #1;
        check_outputs("reset");
        check32("ready", {31'h0, bus_req_ready}, 32'h1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, "vec");
            check32($sformatf("vec%0d rdata", i), bus_rsp_rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d gpio", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
        end

        // Blink with divisor 3: half-period of 4 edges, visible one edge later.
        step(1'b1, 1'b1, 5'h00, 32'h00, "blink setup");
        step(1'b1, 1'b1, 5'h10, 32'h01, "blink setup");
        step(1'b1, 1'b1, 5'h14, 32'h03, "blink div3");
        for (int k = 1; k <= 16; k++) begin
            idle("blink3");
            check32($sformatf("blink3 k%0d", k), {24'h0, gpio_out}, 32'(((k - 1) / 4) % 2));
            if (k == 6) begin
                step(1'b1, 1'b1, 5'h14, 32'h01, "blink div1");
                break;
            end
        end
        for (int k = 1; k <= 8; k++) begin
            idle("blink1");
            check32($sformatf("blink1 k%0d", k), {24'h0, gpio_out}, 32'(((k - 1) / 2) % 2));
        end

        // Input synchronizer latency.
        step(1'b1, 1'b1, 5'h10, 32'h00, "sync setup");
        idle("sync"); idle("sync");
        gpio_in = 8'h3C;
        step(1'b1, 1'b0, 5'h18, 32'h0, "in read");
        check32("in read1", bus_rsp_rdata, 32'h0);
        step(1'b1, 1'b0, 5'h18, 32'h0, "in read");
        check32("in read2", bus_rsp_rdata, 32'h0);
        step(1'b1, 1'b0, 5'h18, 32'h0, "in read");
        check32("in read3", bus_rsp_rdata, 32'h3C);
        step(1'b1, 1'b0, 5'h1C, 32'h0, "unmapped");
        check32("unmapped rsp_valid", {31'h0, bus_rsp_valid}, 32'h1);

        for (int n = 0; n < 400; n++) begin
            logic        v, w;
            logic [4:0]  a;
            logic [31:0] d;
            gpio_in = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            if (a[4:2] == 3'd5 && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 5));
            step(v, w, a, d, "rand");
        end

        // Reset mid-burst: the request presented with reset is dropped.
        step(1'b1, 1'b1, 5'h10, 32'h00, "rst setup");
        step(1'b1, 1'b1, 5'h00, 32'hA5, "rst burst");
        step(1'b1, 1'b1, 5'h04, 32'h01, "rst burst");
        bus_req_valid = 1'b1; bus_req_wr = 1'b0; bus_req_addr = 5'h00; bus_req_wdata = 0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 5'h00, 32'h0);
        #1;
        check_outputs("rst burst");
        check32("pre-reset gpio nonzero", {31'h0, gpio_out != 8'h0}, 32'h1);
        @(negedge clk);
        bus_req_wr = 1'b1; bus_req_addr = 5'h08; bus_req_wdata = 32'hFF;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async reset");
        @(posedge clk);
        #1;
        check_outputs("held reset");
        @(negedge clk);
        bus_req_valid = 1'b0;
        reset = 1'b0;
        idle("post reset");
        step(1'b1, 1'b0, 5'h00, 32'h0, "post reset");
        check32("post reset OUT", bus_rsp_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
